// File: rtl/nexi_uart_wb_arbiter_pkg.sv
// rtl/nexi_uart_wb_arbiter_pkg.sv - shared types and constants for the UART Wishbone arbiter
//
// Package nexi_uart_arb_pkg
//   UART_AW / UART_DW : width of the UART 16550-lite register port (address / data)
//   NREQ_MAX          : largest supported number of bus masters
//   arb_state_e       : one-hot arbiter FSM encoding
package nexi_uart_arb_pkg;

  localparam int UART_AW  = 3;
  localparam int UART_DW  = 8;
  localparam int NREQ_MAX = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_BUSY    = 4'b0010,
    ST_RELEASE = 4'b0100,
    ST_ABORT   = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/nexi_uart_wb_arbiter_if.sv
// rtl/nexi_uart_wb_arbiter_if.sv - master-side and UART-side Wishbone signals of the arbiter
//
// Interface nexi_uart_wb_arbiter_if #(NREQ)
//   m_cyc_i/m_stb_i/m_we_i [NREQ]  per-master request signals
//   m_addr_i [3*NREQ], m_data_i [8*NREQ]  packed per-master address / write data
//   m_ack_o/m_err_o [NREQ]         ack and watchdog abort, routed to the owner
//   m_data_o [8]                   read data broadcast
//   grant_o [NREQ]                 one-hot current owner
//   s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o  towards the UART
//   s_ack_i/s_data_i               from the UART
// Modports: slave = the arbiter, master = the environment (bus masters + UART).
interface nexi_uart_wb_arbiter_if #(
  parameter int NREQ = 2
);
  import nexi_uart_arb_pkg::*;

  logic [NREQ-1:0]         m_cyc_i;
  logic [NREQ-1:0]         m_stb_i;
  logic [NREQ-1:0]         m_we_i;
  logic [UART_AW*NREQ-1:0] m_addr_i;
  logic [UART_DW*NREQ-1:0] m_data_i;
  logic [NREQ-1:0]         m_ack_o;
  logic [NREQ-1:0]         m_err_o;
  logic [UART_DW-1:0]      m_data_o;
  logic [NREQ-1:0]         grant_o;
  logic                    s_cyc_o;
  logic                    s_stb_o;
  logic                    s_we_o;
  logic [UART_AW-1:0]      s_addr_o;
  logic [UART_DW-1:0]      s_data_o;
  logic                    s_ack_i;
  logic [UART_DW-1:0]      s_data_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
    output m_ack_o, m_err_o, m_data_o, grant_o,
           s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
    input  m_ack_o, m_err_o, m_data_o, grant_o,
           s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );

endinterface

// File: rtl/nexi_uart_wb_arbiter_rr_pick.sv
// rtl/nexi_uart_wb_arbiter_rr_pick.sv - combinational round-robin picker
//
// Module nexi_rr_pick #(NREQ, PW)
//   i_req   [NREQ]  request vector
//   i_ptr   [PW]    index with highest priority this round
//   o_gnt   [NREQ]  one-hot winner: first requester at or after i_ptr, wrapping
//   o_valid         at least one request present
module nexi_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_valid
);

  logic [2*NREQ-1:0] w_req_dbl;
  logic [2*NREQ-1:0] w_gnt_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic [NREQ-1:0]   w_gnt_rot;

  // Rotate right so the pointer lands on bit 0, take the lowest set bit,
  // then rotate back. Doubling the vector turns the rotates into plain shifts.
  assign w_req_dbl = {i_req, i_req} >> i_ptr;
  assign w_req_rot = w_req_dbl[NREQ-1:0];
  assign w_gnt_rot = w_req_rot & (~w_req_rot + 1'b1);
  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << i_ptr;
  assign o_gnt     = w_gnt_dbl[2*NREQ-1:NREQ];
  assign o_valid   = |i_req;

endmodule

// File: rtl/nexi_uart_wb_arbiter.sv
// rtl/nexi_uart_wb_arbiter.sv - round-robin Wishbone arbiter in front of the UART register port
//
// Module nexi_uart_wb_arbiter #(NREQ=2, TIMEOUT_CYC=64)
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   bus    nexi_uart_wb_arbiter_if.slave: master requests in, UART port out,
//          ack/err/read data back to the current owner, grant_o one-hot owner
// Optional feature: define NEXI_UART_ARB_WATCHDOG_EN to abort a grant after
// TIMEOUT_CYC strobed cycles without a slave ack.
module nexi_uart_wb_arbiter
  import nexi_uart_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  nexi_uart_wb_arbiter_if.slave        bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("nexi_uart_wb_arbiter: unsupported NREQ or TIMEOUT_CYC");
  end

  arb_state_e      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;

  logic [NREQ-1:0] w_pick_gnt;
  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic [PW-1:0]   w_ptr_next;
  logic            w_busy;
  logic            w_owner_cyc;
  logic            w_owner_stb;
  logic            w_timeout;

  nexi_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req   (bus.m_cyc_i),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_gnt[i]) w_pick_idx = PW'(i);
    end
  end

  // The master just served moves to the back of the queue.
  assign w_ptr_next  = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_busy      = (r_state == ST_BUSY);
  assign w_owner_cyc = bus.m_cyc_i[r_owner];
  assign w_owner_stb = bus.m_stb_i[r_owner];

`ifdef NEXI_UART_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wd_cnt;

  assign w_timeout = w_busy && (r_wd_cnt == WDW'(TIMEOUT_CYC));

  // Counts strobed-but-unacked BUSY cycles; IDLE precedes every grant, so
  // clearing there restarts the count for each new owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_IDLE || bus.s_ack_i) begin
      r_wd_cnt <= '0;
    end else if (w_busy && bus.s_stb_o) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Slave-side mux: only the owner reaches the UART, and only while BUSY.
  // Gating by state also keeps the slave idle for the RELEASE cycle.
  assign bus.s_cyc_o  = w_busy & w_owner_cyc & ~w_timeout;
  assign bus.s_stb_o  = w_busy & w_owner_stb & ~w_timeout;
  assign bus.s_we_o   = w_busy & bus.m_we_i[r_owner];
  assign bus.s_addr_o = w_busy ? bus.m_addr_i[r_owner*UART_AW +: UART_AW] : '0;
  assign bus.s_data_o = w_busy ? bus.m_data_i[r_owner*UART_DW +: UART_DW] : '0;

  // The slave ack is a level held until stb drops, so it is qualified with
  // the owner's strobe to avoid a second ack between beats.
  assign bus.m_ack_o  = w_busy ? (r_grant & {NREQ{bus.s_ack_i & w_owner_stb}}) : '0;
  assign bus.m_err_o  = r_grant & {NREQ{w_timeout}};
  assign bus.m_data_o = w_busy ? bus.s_data_i : '0;
  assign bus.grant_o  = r_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_gnt;
            r_owner <= w_pick_idx;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_owner_cyc) begin
            r_grant  <= '0;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_RELEASE;
          end else if (w_timeout) begin
            r_state <= ST_ABORT;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
`ifdef NEXI_UART_ARB_WATCHDOG_EN
        ST_ABORT: begin
          if (!w_owner_cyc) begin
            r_grant  <= '0;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_RELEASE;
          end
        end
`endif
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexi_uart_wb_arbiter.sv
// tb/tb_nexi_uart_wb_arbiter.sv - scoreboard bench for the UART Wishbone arbiter
module tb_nexi_uart_wb_arbiter;

  localparam int NREQ     = 2;
  localparam int WAIT_MAX = 100;

  typedef struct {
    logic [1:0] ack;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
  } sb_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  sb_q[$];
  logic [7:0] ref_mem [8];
  logic [7:0] smem [8];
  int   s_wait;
  int   s_dly;
  bit   s_mute;

  nexi_uart_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  nexi_uart_wb_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model: level ack after s_dly stalled cycles, held until stb drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_ack_i  <= 1'b0;
      bus.s_data_i <= '0;
      s_wait       <= 0;
      for (int i = 0; i < 8; i++) smem[i] <= '0;
    end else if (bus.s_cyc_o && bus.s_stb_o) begin
      if (!bus.s_ack_i && !s_mute) begin
        if (s_wait >= s_dly) begin
          bus.s_ack_i <= 1'b1;
          s_wait      <= 0;
          if (bus.s_we_o) smem[bus.s_addr_o] <= bus.s_data_o;
          else            bus.s_data_i <= smem[bus.s_addr_o];
        end else begin
          s_wait <= s_wait + 1;
        end
      end
    end else begin
      bus.s_ack_i <= 1'b0;
      s_wait      <= 0;
    end
  end

  // Scoreboard consumer: every forwarded ack must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      sb_t e;
      check("ack_owner", 32'(bus.m_ack_o & ~bus.grant_o), 0);
`ifndef NEXI_UART_ARB_WATCHDOG_EN
      check("no_err", 32'(bus.m_err_o), 0);
`endif
      if (bus.m_ack_o != '0) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 32'(bus.m_ack_o), 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_ack", 32'(bus.m_ack_o), 32'(e.ack));
          check("sb_addr", 32'(bus.s_addr_o), 32'(e.addr));
          check("sb_we", 32'(bus.s_we_o), 32'(e.we));
          if (e.we) check("sb_wdata", 32'(bus.s_data_o), 32'(e.data));
          else      check("sb_rdata", 32'(bus.m_data_o), 32'(e.data));
        end
      end
    end
  end

  task automatic expect_xfer(input int m, input bit we, input logic [2:0] a,
                             input logic [7:0] d, input int beats);
    sb_t e;
    for (int b = 0; b < beats; b++) begin
      e.ack    = '0;
      e.ack[m] = 1'b1;
      e.we     = we;
      e.addr   = a + 3'(b);
      if (we) begin
        e.data = d + 8'(b);
        ref_mem[e.addr] = e.data;
      end else begin
        e.data = ref_mem[e.addr];
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic wb_cycle(input int m, input bit we, input logic [2:0] a,
                          input logic [7:0] d, input int beats, input int dly);
    int n;
    repeat (dly) @(posedge clk);
    @(posedge clk); #1;
    bus.m_cyc_i[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      bus.m_stb_i[m]        = 1'b1;
      bus.m_we_i[m]         = we;
      bus.m_addr_i[m*3 +: 3] = a + 3'(b);
      bus.m_data_i[m*8 +: 8] = d + 8'(b);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.m_ack_o[m] && n < WAIT_MAX);
      if (!bus.m_ack_o[m]) check($sformatf("m%0d_ack_timeout", m), 0, 1);
      @(posedge clk); #1;
      bus.m_stb_i[m] = 1'b0;
      if (b == beats - 1) bus.m_cyc_i[m] = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int n;
    int z;
    rst = 1'b1;
    s_mute = 1'b0;
    s_dly  = 1;
    bus.m_cyc_i  = '0;
    bus.m_stb_i  = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant_o), 0);
    check("rst_slave", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o}, 0);
    check("rst_master", {bus.m_ack_o, bus.m_err_o, bus.m_data_o}, 0);
    rst = 1'b0;

    // Single master write with one-cycle grant latency.
    expect_xfer(0, 1, 3'd1, 8'h41, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd1, 8'h41, 1, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        check("t1_latency", 32'(bus.grant_o), 0);
        @(negedge clk);
        check("t1_grant", 32'(bus.grant_o), 1);
        check("t1_scyc", 32'(bus.s_cyc_o), 1);
        check("t1_addr", 32'(bus.s_addr_o), 1);
        check("t1_data", 32'(bus.s_data_o), 32'h41);
      end
    join
    @(negedge clk);
    check("t1_cyc_dropped", 32'(bus.s_cyc_o), 0);
    @(negedge clk);
    check("t1_release_grant", 32'(bus.grant_o), 0);
    check("t1_release_scyc", 32'(bus.s_cyc_o), 0);

    // Contention straight after reset: m0 first, two idle cycles, then m1.
    do_reset();
    expect_xfer(0, 1, 3'd0, 8'h5A, 1);
    expect_xfer(1, 1, 3'd2, 8'h33, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd0, 8'h5A, 1, 0);
      wb_cycle(1, 1, 3'd2, 8'h33, 1, 0);
      begin
        n = 0;
        while (bus.grant_o !== 2'b01 && n < WAIT_MAX) begin @(negedge clk); n++; end
        check("t2_first", 32'(bus.grant_o), 1);
        while (bus.grant_o === 2'b01 && n < 2*WAIT_MAX) begin @(negedge clk); n++; end
        z = 0;
        while (bus.grant_o === 2'b00 && z < WAIT_MAX) begin @(negedge clk); z++; end
        check("t2_gap", z, 2);
        check("t2_second", 32'(bus.grant_o), 2);
      end
    join
    // Pointer wrapped after m1: the next tie goes to m0.
    expect_xfer(0, 1, 3'd4, 8'h11, 1);
    expect_xfer(1, 1, 3'd5, 8'h22, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd4, 8'h11, 1, 0);
      wb_cycle(1, 1, 3'd5, 8'h22, 1, 0);
    join

    // Read by m1 while m0 waits with cyc high.
    expect_xfer(1, 0, 3'd0, 8'h00, 1);
    expect_xfer(0, 1, 3'd6, 8'h66, 1);
    @(posedge clk);
    fork
      wb_cycle(1, 0, 3'd0, 8'h00, 1, 0);
      wb_cycle(0, 1, 3'd6, 8'h66, 1, 1);
    join

    // m0 was served last, so a tie now goes to m1.
    expect_xfer(1, 1, 3'd3, 8'h30, 1);
    expect_xfer(0, 1, 3'd7, 8'h70, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd7, 8'h70, 1, 0);
      wb_cycle(1, 1, 3'd3, 8'h30, 1, 0);
    join

    // Burst lock: m0 keeps the grant for three beats while m1 waits.
    expect_xfer(0, 1, 3'd1, 8'hA0, 3);
    expect_xfer(1, 1, 3'd2, 8'hB0, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd1, 8'hA0, 3, 0);
      wb_cycle(1, 1, 3'd2, 8'hB0, 1, 2);
      begin
        n = 0;
        while (bus.grant_o !== 2'b01 && n < WAIT_MAX) begin @(negedge clk); n++; end
        check("t4_granted", 32'(bus.grant_o), 1);
        while (bus.m_cyc_i[0] && n < 4*WAIT_MAX) begin
          check("t4_lock", 32'(bus.grant_o), 1);
          @(negedge clk);
          n++;
        end
      end
    join

`ifdef NEXI_UART_ARB_WATCHDOG_EN
    // Hung slave: eight stalled strobe cycles, then a one-cycle error pulse.
    begin
      int  stalls;
      bit  err_seen;
      s_mute = 1'b1;
      stalls = 0;
      err_seen = 1'b0;
      @(posedge clk); #1;
      bus.m_cyc_i[0] = 1'b1;
      bus.m_stb_i[0] = 1'b1;
      bus.m_we_i[0]  = 1'b1;
      bus.m_addr_i[2:0] = 3'd5;
      bus.m_data_i[7:0] = 8'h77;
      for (int i = 0; i < 4*WAIT_MAX && !err_seen; i++) begin
        @(negedge clk);
        if (bus.m_err_o != '0) begin
          err_seen = 1'b1;
          check("wd_err", 32'(bus.m_err_o), 1);
          check("wd_stalls", stalls, 8);
          check("wd_scyc", 32'(bus.s_cyc_o), 0);
        end else if (bus.s_stb_o) begin
          stalls++;
        end
      end
      check("wd_seen", 32'(err_seen), 1);
      @(negedge clk);
      check("wd_pulse_end", 32'(bus.m_err_o), 0);
      check("wd_abort_scyc", 32'(bus.s_cyc_o), 0);
      check("wd_abort_grant", 32'(bus.grant_o), 1);
      @(posedge clk); #1;
      bus.m_cyc_i[0] = 1'b0;
      bus.m_stb_i[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wd_release", 32'(bus.grant_o), 0);
      s_mute = 1'b0;
    end
`endif

    // Async reset in the middle of m1's cycle; pointer must return to m0.
    expect_xfer(0, 1, 3'd2, 8'hC3, 1);
    @(posedge clk);
    wb_cycle(0, 1, 3'd2, 8'hC3, 1, 0);
    s_dly = 4;
    @(posedge clk); #1;
    bus.m_cyc_i[1] = 1'b1;
    bus.m_stb_i[1] = 1'b1;
    bus.m_we_i[1]  = 1'b0;
    bus.m_addr_i[5:3] = 3'd3;
    n = 0;
    while (bus.grant_o !== 2'b10 && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("t6_busy_grant", 32'(bus.grant_o), 2);
    check("t6_busy_scyc", 32'(bus.s_cyc_o), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(bus.grant_o), 0);
    check("t6_rst_slave", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o}, 0);
    check("t6_rst_master", {bus.m_ack_o, bus.m_err_o, bus.m_data_o}, 0);
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    s_dly = 1;
    @(posedge clk); #1 rst = 1'b0;
    expect_xfer(0, 1, 3'd3, 8'hD4, 1);
    expect_xfer(1, 1, 3'd4, 8'hE5, 1);
    @(posedge clk);
    fork
      wb_cycle(0, 1, 3'd3, 8'hD4, 1, 0);
      wb_cycle(1, 1, 3'd4, 8'hE5, 1, 0);
    join

    repeat (4) @(posedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
